// File: rtl/frame_fetch_if.sv
// rtl/frame_fetch_if.sv - handshake/bus bundle between frame sequencer, frame memory, IRAM and cores
//
// Purpose: groups every non-clock/reset signal of frame_fetch_sequencer.
//   master modport : sequencer side (drives addresses, IRAM writes, run_start, status)
//   slave modport  : environment side (frame memory, shader cores, command source)
// Signals:
//   repeat_frame, end_repeating : 1-cycle command pulses into the sequencer
//   data_input                  : external frame memory read data (1-cycle latency)
//   input_addr                  : external frame memory read address
//   iram_we/iram_waddr/iram_wdata : local instruction RAM write port
//   run_start / run_done        : core launch pulse / core completion pulse
//   busy, frame_base, frame_count : status
//   frame_sum                   : running checksum of fetched words (FETCH_CHECKSUM_EN only)
interface frame_fetch_if #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int LOCAL_AW = 9
);
    logic                repeat_frame;
    logic                end_repeating;
    logic [DATA_W-1:0]   data_input;
    logic [ADDR_W-1:0]   input_addr;
    logic                iram_we;
    logic [LOCAL_AW-1:0] iram_waddr;
    logic [DATA_W-1:0]   iram_wdata;
    logic                run_start;
    logic                run_done;
    logic                busy;
    logic [ADDR_W-1:0]   frame_base;
    logic [15:0]         frame_count;
`ifdef FETCH_CHECKSUM_EN
    logic [DATA_W-1:0]   frame_sum;
`endif

    modport master (
        input  repeat_frame, end_repeating, data_input, run_done,
        output input_addr, iram_we, iram_waddr, iram_wdata, run_start,
               busy, frame_base, frame_count
`ifdef FETCH_CHECKSUM_EN
        , output frame_sum
`endif
    );

    modport slave (
        output repeat_frame, end_repeating, data_input, run_done,
        input  input_addr, iram_we, iram_waddr, iram_wdata, run_start,
               busy, frame_base, frame_count
`ifdef FETCH_CHECKSUM_EN
        , input frame_sum
`endif
    );
endinterface

// File: rtl/frame_fetch_sequencer.sv
// rtl/frame_fetch_sequencer.sv - frame fetch / launch / repeat controller for the shader cores
//
// Purpose: streams FRAME_WORDS words from external frame memory into the local IRAM, pulses
//   run_start, waits for run_done, then either re-runs the frame or advances to the next one.
//   Fetch and execution never overlap.
// Ports:
//   clk  : system clock (posedge)
//   KEY0 : synchronous active-low reset
//   bus  : frame_fetch_if.master (commands, frame memory read, IRAM write, core handshake, status)
// Configuration macro: FETCH_CHECKSUM_EN adds bus.frame_sum, the mod 2**DATA_W sum of the
//   words written during the most recent fetch.
module frame_fetch_sequencer #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int MEM_WORDS   = 1024,
    parameter int FRAME_WORDS = 288,
    parameter int LOCAL_AW    = 9
) (
    input  logic           clk,
    input  logic           KEY0,
    frame_fetch_if.master  bus
);
    localparam int CNT_W = LOCAL_AW + 1;

    typedef enum logic [2:0] {BOOT, FETCH, LAUNCH, RUN, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                rd_q, wr_q;
    logic [LOCAL_AW-1:0] rd_idx_q, waddr_q;
    logic [ADDR_W-1:0]   addr_q, base_q;
    logic [15:0]         count_q;
    logic                pend_rep_q, pend_end_q;
    logic                run_start, busy;

    logic                cmd_end, cmd_rep, done_ok, fetch_last, advance;
    logic [ADDR_W:0]     base_sum, base_wrap, addr_sum, addr_wrap;

    // Pending and same-cycle commands are merged; end_repeating always wins.
    assign cmd_end    = pend_end_q | bus.end_repeating;
    assign cmd_rep    = pend_rep_q | bus.repeat_frame;
    assign done_ok    = bus.run_done && (state_q == RUN || state_q == LAUNCH);
    assign fetch_last = wr_q && (waddr_q == LOCAL_AW'(FRAME_WORDS - 1));
    assign advance    = (state_q == HOLD && bus.end_repeating) || (done_ok && cmd_end);

    // Both operands stay below MEM_WORDS, so one conditional subtract performs the modulo.
    assign base_sum  = {1'b0, base_q} + (ADDR_W+1)'(FRAME_WORDS);
    assign base_wrap = (base_sum >= (ADDR_W+1)'(MEM_WORDS)) ? base_sum - (ADDR_W+1)'(MEM_WORDS) : base_sum;
    assign addr_sum  = {1'b0, base_q} + (ADDR_W+1)'(cnt_q);
    assign addr_wrap = (addr_sum >= (ADDR_W+1)'(MEM_WORDS)) ? addr_sum - (ADDR_W+1)'(MEM_WORDS) : addr_sum;

    always_ff @(posedge clk) begin
        if (!KEY0) state_q <= BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:   state_d = FETCH;
            FETCH:  if (fetch_last) state_d = LAUNCH;
            LAUNCH, RUN: begin
                if (done_ok) begin
                    if (cmd_end)      state_d = FETCH;
                    else if (cmd_rep) state_d = LAUNCH;
                    else              state_d = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            HOLD: begin
                if (bus.end_repeating)     state_d = FETCH;
                else if (bus.repeat_frame) state_d = LAUNCH;
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        run_start = 1'b0;
        busy      = 1'b0;
        case (state_q)
            FETCH:   busy = 1'b1;
            LAUNCH:  run_start = 1'b1;
            RUN:     busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!KEY0) begin
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_idx_q   <= '0;
            waddr_q    <= '0;
            addr_q     <= '0;
            base_q     <= '0;
            count_q    <= '0;
            pend_rep_q <= 1'b0;
            pend_end_q <= 1'b0;
        end else begin
            if (done_ok) begin
                if (cmd_end) begin
                    pend_end_q <= 1'b0;
                    pend_rep_q <= 1'b0;
                end else if (cmd_rep) begin
                    pend_rep_q <= 1'b0;
                end
            end else if (state_q != HOLD) begin
                pend_end_q <= pend_end_q | bus.end_repeating;
                pend_rep_q <= pend_rep_q | bus.repeat_frame;
            end

            if (state_q == BOOT)  base_q <= '0;
            else if (advance)     base_q <= base_wrap[ADDR_W-1:0];

            // Address issue stage; data returns one cycle later and is written from wr_q.
            if (state_q == FETCH && cnt_q < CNT_W'(FRAME_WORDS)) begin
                addr_q   <= addr_wrap[ADDR_W-1:0];
                rd_q     <= 1'b1;
                rd_idx_q <= cnt_q[LOCAL_AW-1:0];
                cnt_q    <= cnt_q + CNT_W'(1);
            end else begin
                rd_q <= 1'b0;
                if (state_q != FETCH) cnt_q <= '0;
            end

            wr_q <= rd_q;
            if (rd_q) waddr_q <= rd_idx_q;

            if (state_q == FETCH && fetch_last) count_q <= count_q + 16'd1;
        end
    end

`ifdef FETCH_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    always_ff @(posedge clk) begin
        if (!KEY0)                                   sum_q <= '0;
        else if (state_q != FETCH && state_d == FETCH) sum_q <= '0;
        else if (wr_q)                               sum_q <= sum_q + bus.data_input;
    end
    assign bus.frame_sum = sum_q;
`endif

    assign bus.input_addr  = addr_q;
    assign bus.iram_we     = wr_q;
    assign bus.iram_waddr  = waddr_q;
    assign bus.iram_wdata  = wr_q ? bus.data_input : '0;
    assign bus.run_start   = run_start;
    assign bus.busy        = busy;
    assign bus.frame_base  = base_q;
    assign bus.frame_count = count_q;
endmodule

// File: tb/tb_frame_fetch_sequencer.sv
// tb/tb_frame_fetch_sequencer.sv - self-checking bench for frame_fetch_sequencer
module tb_frame_fetch_sequencer;
    localparam int ADDR_W = 20, DATA_W = 16, MEM = 1024, FW = 288, LAW = 9;

    logic clk = 1'b0;
    logic KEY0;
    always #5 clk = ~clk;

    frame_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCAL_AW(LAW)) bus();

    frame_fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM),
                            .FRAME_WORDS(FW), .LOCAL_AW(LAW)) dut (
        .clk(clk), .KEY0(KEY0), .bus(bus));

    logic [DATA_W-1:0] mem [MEM];
    initial for (int i = 0; i < MEM; i++) mem[i] = DATA_W'(i);
    always @(posedge clk) bus.data_input <= mem[int'(bus.input_addr) % MEM];

    int checks = 0, failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: phase 0 boot, 1 fetch, 2 launch, 3 run, 4 hold; m_t counts cycles since fetch entry.
    int m_phase, m_t, m_base, m_count, m_addr, m_sum;
    bit m_pend_end, m_pend_rep, m_valid = 0;
    int exp_addr, widx;
    bit exp_we, e_act, r_act;

    always @(negedge clk) begin
        if (m_valid) begin
            exp_addr = (m_phase == 1 && m_t >= 1 && m_t <= FW) ? (m_base + m_t - 1) % MEM : m_addr;
            exp_we   = (m_phase == 1 && m_t >= 2 && m_t <= FW + 1);
            chk("input_addr", bus.input_addr, exp_addr);
            m_addr = exp_addr;
            chk("iram_we", bus.iram_we, exp_we);
`ifdef FETCH_CHECKSUM_EN
            chk("frame_sum", bus.frame_sum, m_sum);
`endif
            if (exp_we) begin
                widx = (m_base + m_t - 2) % MEM;
                chk("iram_waddr", bus.iram_waddr, m_t - 2);
                chk("iram_wdata", bus.iram_wdata, mem[widx]);
                m_sum = (m_sum + int'(mem[widx])) % 65536;
            end
            chk("run_start", bus.run_start, m_phase == 2);
            chk("busy", bus.busy, m_phase == 1 || m_phase == 3);
            chk("frame_base", bus.frame_base, m_base);
            chk("frame_count", bus.frame_count, m_count);
        end
        if (!KEY0) begin
            m_valid = 1; m_phase = 0; m_t = 0; m_base = 0; m_count = 0;
            m_addr = 0; m_sum = 0; m_pend_end = 0; m_pend_rep = 0;
        end else if (m_valid) begin
            e_act = m_pend_end | bus.end_repeating;
            r_act = m_pend_rep | bus.repeat_frame;
            case (m_phase)
                0: begin
                    m_pend_end = e_act; m_pend_rep = r_act;
                    m_phase = 1; m_t = 0; m_base = 0; m_sum = 0;
                end
                1: begin
                    m_pend_end = e_act; m_pend_rep = r_act;
                    if (m_t == FW + 1) begin
                        m_phase = 2; m_count = (m_count + 1) % 65536;
                    end else m_t++;
                end
                2, 3: begin
                    if (bus.run_done) begin
                        if (e_act) begin
                            m_base = (m_base + FW) % MEM; m_phase = 1; m_t = 0; m_sum = 0;
                            m_pend_end = 0; m_pend_rep = 0;
                        end else if (r_act) begin
                            m_phase = 2; m_pend_rep = 0;
                        end else m_phase = 4;
                    end else begin
                        m_pend_end = e_act; m_pend_rep = r_act; m_phase = 3;
                    end
                end
                default: begin
                    if (bus.end_repeating) begin
                        m_base = (m_base + FW) % MEM; m_phase = 1; m_t = 0; m_sum = 0;
                    end else if (bus.repeat_frame) m_phase = 2;
                end
            endcase
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic pulse_rep;  bus.repeat_frame = 1;  tick; bus.repeat_frame = 0;  endtask
    task automatic pulse_end;  bus.end_repeating = 1; tick; bus.end_repeating = 0; endtask
    task automatic pulse_done; bus.run_done = 1;      tick; bus.run_done = 0;      endtask

    task automatic wait_start;
        bit seen = 0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            tick;
            seen = bus.run_start;
        end
        if (!seen) chk("run_start_timeout", 0, 1);
    endtask

    task automatic wait_write(input int idx);
        bit seen = 0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            tick;
            seen = bus.iram_we && (int'(bus.iram_waddr) == idx);
        end
        if (!seen) chk("write_timeout", 0, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_input_addr"}, bus.input_addr, 0);
        chk({tag, "_iram_we"}, bus.iram_we, 0);
        chk({tag, "_iram_waddr"}, bus.iram_waddr, 0);
        chk({tag, "_iram_wdata"}, bus.iram_wdata, 0);
        chk({tag, "_run_start"}, bus.run_start, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_frame_base"}, bus.frame_base, 0);
        chk({tag, "_frame_count"}, bus.frame_count, 0);
    endtask

    int bases [4] = '{288, 576, 864, 128};
    int extra_starts;

    initial begin
        KEY0 = 0;
        bus.repeat_frame = 0; bus.end_repeating = 0; bus.run_done = 0;
        repeat (3) tick;
        check_reset("rst");
        KEY0 = 1;

        wait_start;
        chk("first_count", bus.frame_count, 1);
        chk("first_base", bus.frame_base, 0);
`ifdef FETCH_CHECKSUM_EN
        chk("first_sum", bus.frame_sum, 41328);
`endif
        repeat (3) tick;
        pulse_done;
        repeat (2) tick;
        chk("hold_busy", bus.busy, 0);
        pulse_rep;
        chk("repeat_start", bus.run_start, 1);
        chk("repeat_base", bus.frame_base, 0);
        repeat (3) tick;
        pulse_done;
        repeat (2) tick;

        for (int i = 0; i < 4; i++) begin
            pulse_end;
            if (i == 2) begin
                wait_write(159);
                chk("wrap_word159", bus.iram_wdata, 1023);
                wait_write(160);
                chk("wrap_word160", bus.iram_wdata, 0);
            end
            wait_start;
            chk("adv_base", bus.frame_base, bases[i]);
            chk("adv_count", bus.frame_count, i + 2);
            repeat (3) tick;
            pulse_done;
            repeat (2) tick;
        end

        pulse_rep;
        repeat (2) tick;
        pulse_rep;
        pulse_end;
        tick;
        pulse_done;
        wait_start;
        chk("pend_base", bus.frame_base, 416);
        chk("pend_count", bus.frame_count, 6);
        repeat (3) tick;
        pulse_done;
        extra_starts = 0;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (bus.run_start) extra_starts++;
        end
        chk("pend_single_start", extra_starts, 0);

        pulse_end;
        wait_write(100);
        KEY0 = 0;
        tick;
        check_reset("abort");
        KEY0 = 1;
        wait_start;
        chk("restart_base", bus.frame_base, 0);
        chk("restart_count", bus.frame_count, 1);
`ifdef FETCH_CHECKSUM_EN
        chk("restart_sum", bus.frame_sum, 41328);
`endif
        repeat (3) tick;
        pulse_done;
        repeat (3) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
